polaris_bus_arbiter: RTL and testbench

- Shares the single external bus between the Polaris CPU's instruction-fetch master (I) and load/store master (D).
- Sits between the CPU core ports and the system bus.
- Latches the winning request, drives the bus until the slave acknowledges, and routes ack, read data and error back to the owning master.
- A watchdog aborts transfers the slave never acknowledges.

---
 rtl/polaris_bus_pkg.sv | 42 ++++
 rtl/polaris_bus_watchdog.sv | 60 ++++++
 rtl/polaris_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_polaris_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polaris_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : polaris_bus_pkg
// Description : Shared encodings for the Polaris bus arbiter and the bridges
//               built around it. Holds bus size codes, arbiter state and grant
//               codes, the latched-request record and a request-pending helper.
// Revision    : 1.0 - initial release
// ============================================================================
package polaris_bus_pkg;

  // Bus transfer size codes (xsiz/isiz/dsiz)
  localparam logic [1:0] SIZ_NONE  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_DWORD = 2'b11;

  // Arbiter states. The GNT encodings equal the grant codes so the state
  // register can be presented directly on grant_o.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GNT_I = 2'b01;
  localparam logic [1:0] ST_GNT_D = 2'b10;

  // Owner codes on grant_o
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  // Transfer latched from the winning master and held on the bus
  typedef struct packed {
    logic [63:0] adr;
    logic [1:0]  siz;
    logic        we;
    logic [63:0] dat;
  } bus_req_t;

  // A master is requesting whenever its size field is non-zero
  function automatic logic req_pending(input logic [1:0] siz);
    return siz != SIZ_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/polaris_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : polaris_bus_watchdog
// Description : TW-bit cycle counter with clear/enable and a registered
//               expire flag. expire_o is high while the count equals
//               TIMEOUT-1, i.e. during the TIMEOUT-th enabled cycle after a
//               clear. TIMEOUT = 0 disables expiry entirely.
// Ports       : clk_i    - clock
//               reset_i  - asynchronous active-low reset
//               clr_i    - return count to zero (wins over en_i)
//               en_i     - advance count by one
//               expire_o - registered compare, count == TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module polaris_bus_watchdog #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 5
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned   c_LIMIT_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] c_LIMIT     = TW'(c_LIMIT_INT);
  localparam logic          c_ENABLED   = (TIMEOUT != 0);
  // With TIMEOUT = 1 the very first cycle after a clear is already the last
  localparam logic          c_EXP_RST   = (TIMEOUT == 1);

  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_nxt;
  logic          r_expire;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_i) begin
      w_cnt_nxt = '0;
    end else if (en_i) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Compare against the next count so the flag lines up with the count
  // value it describes without a combinational compare on the output.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt    <= '0;
      r_expire <= c_EXP_RST;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_expire <= c_ENABLED && (w_cnt_nxt == c_LIMIT);
    end
  end

  assign expire_o = r_expire;

endmodule
`default_nettype wire

// File: rtl/polaris_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : polaris_bus_arbiter
// Description : Shares the external bus between the instruction-fetch master
//               (I) and the load/store master (D). Latches the winning
//               request onto the bus, holds it until the slave acks or the
//               watchdog expires, and routes ack/data/err to the owner.
// Ports       : clk_i, reset_i (async, active-low)
//               I master : iadr_i, isiz_i -> iack_o, idat_o, ierr_o
//               D master : dadr_i, dsiz_i, dwe_i, ddat_i
//                          -> dack_o, ddat_o, derr_o
//               Bus      : xadr_o, xsiz_o, xwe_o, xdat_o <- xack_i, xdat_i
//               grant_o  : current owner, 00 none, 01 I, 10 D
// Revision    : 1.0 - initial release
// ============================================================================
module polaris_bus_arbiter
  import polaris_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] iadr_i,
  input  logic [1:0]  isiz_i,
  output logic        iack_o,
  output logic [31:0] idat_o,
  output logic        ierr_o,
  input  logic [63:0] dadr_i,
  input  logic [1:0]  dsiz_i,
  input  logic        dwe_i,
  input  logic [63:0] ddat_i,
  output logic        dack_o,
  output logic [63:0] ddat_o,
  output logic        derr_o,
  output logic [63:0] xadr_o,
  output logic [1:0]  xsiz_o,
  output logic        xwe_o,
  output logic [63:0] xdat_o,
  input  logic        xack_i,
  input  logic [63:0] xdat_i,
  output logic [1:0]  grant_o
);

  logic [1:0] r_state;
  logic       r_lg_d;    // 1: D owned the bus last, so I wins the next tie
  bus_req_t   r_x;

  logic       w_ireq;
  logic       w_dreq;
  logic       w_pick_i;
  logic       w_in_gnt;
  logic       w_own_i;
  logic       w_own_d;
  logic       w_expire;
  logic       w_done;
  logic       w_iack;
  logic       w_dack;
  bus_req_t   w_ipkt;
  bus_req_t   w_dpkt;

  assign w_ireq   = req_pending(isiz_i);
  assign w_dreq   = req_pending(dsiz_i);
  assign w_pick_i = w_ireq && (!w_dreq || r_lg_d);

  // Fetches never write, so we and data are forced to zero for I
  assign w_ipkt = '{adr: iadr_i, siz: isiz_i, we: 1'b0, dat: 64'd0};
  assign w_dpkt = '{adr: dadr_i, siz: dsiz_i, we: dwe_i, dat: ddat_i};

  assign w_own_i  = (r_state == ST_GNT_I);
  assign w_own_d  = (r_state == ST_GNT_D);
  assign w_in_gnt = w_own_i || w_own_d;
  // An ack in the expiry cycle still counts as a normal completion
  assign w_done   = w_in_gnt && (xack_i || w_expire);

  polaris_bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (!w_in_gnt || w_done),
    .en_i     (w_in_gnt && !xack_i),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= ST_IDLE;
      r_lg_d  <= 1'b1;
      r_x     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_i) begin
            r_state <= ST_GNT_I;
            r_x     <= w_ipkt;
          end else if (w_dreq) begin
            r_state <= ST_GNT_D;
            r_x     <= w_dpkt;
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (w_done) begin
            r_state <= ST_IDLE;
            r_x.siz <= SIZ_NONE;
            r_lg_d  <= w_own_d;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_x.siz <= SIZ_NONE;
        end
      endcase
    end
  end

  assign xadr_o  = r_x.adr;
  assign xsiz_o  = r_x.siz;
  assign xwe_o   = r_x.we;
  assign xdat_o  = r_x.dat;
  assign grant_o = r_state;

  assign w_iack = w_own_i && xack_i;
  assign w_dack = w_own_d && xack_i;

  assign iack_o = w_iack;
  assign dack_o = w_dack;
  assign ierr_o = w_own_i && w_expire && !xack_i;
  assign derr_o = w_own_d && w_expire && !xack_i;

  // Fetch word lane is picked by the latched address, not the live input
  assign idat_o = !w_iack ? 32'd0 :
                  (r_x.adr[2] ? xdat_i[63:32] : xdat_i[31:0]);
  assign ddat_o = w_dack ? xdat_i : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_polaris_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_polaris_bus_arbiter
// Description : Self-checking bench for polaris_bus_arbiter (TIMEOUT = 4).
//               Table of per-cycle vectors, directed corner sequences, and
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_polaris_bus_arbiter;

  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [63:0] iadr_i, dadr_i, ddat_i, xdat_i;
  logic [1:0]  isiz_i, dsiz_i;
  logic        dwe_i, xack_i;
  logic        iack_o, ierr_o, dack_o, derr_o, xwe_o;
  logic [31:0] idat_o;
  logic [63:0] ddat_o, xadr_o, xdat_o;
  logic [1:0]  xsiz_o, grant_o;

  int n_checks = 0;
  int n_errors = 0;

  polaris_bus_arbiter #(.TIMEOUT(T), .TW(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .iadr_i(iadr_i), .isiz_i(isiz_i), .iack_o(iack_o), .idat_o(idat_o), .ierr_o(ierr_o),
    .dadr_i(dadr_i), .dsiz_i(dsiz_i), .dwe_i(dwe_i), .ddat_i(ddat_i),
    .dack_o(dack_o), .ddat_o(ddat_o), .derr_o(derr_o),
    .xadr_o(xadr_o), .xsiz_o(xsiz_o), .xwe_o(xwe_o), .xdat_o(xdat_o),
    .xack_i(xack_i), .xdat_i(xdat_i), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    iadr_i = '0; isiz_i = '0; dadr_i = '0; dsiz_i = '0;
    dwe_i = 1'b0; ddat_i = '0; xack_i = 1'b0; xdat_i = '0;
  endtask

  // Leaves reset asserted just after a rising edge; caller releases it
  task automatic reset_assert();
    tick();
    reset_i = 1'b0;
    clear_inputs();
    tick();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [1:0] isiz;
    logic [1:0] dsiz;
    logic       xack;
    logic [1:0] grant;
    logic [1:0] xsiz;
    logic       iack;
    logic       dack;
    logic       derr;
  } vec_t;

  vec_t vt[$];

  // ---------------- reference model ----------------
  // Owner 0 = bus free, 1 = I, 2 = D. waited = GNT cycles already spent.
  int          m_owner, m_last, m_waited;
  logic [63:0] m_adr, m_dat;
  logic [1:0]  m_siz;
  logic        m_we;

  task automatic model_reset();
    m_owner = 0; m_last = 2; m_waited = 0;
    m_adr = '0; m_dat = '0; m_siz = '0; m_we = 1'b0;
  endtask

  task automatic model_check_and_step();
    logic        ack, tmo, iack_e, dack_e;
    logic [31:0] idat_e;
    ack    = (m_owner != 0) && xack_i;
    tmo    = (m_owner != 0) && !xack_i && (m_waited + 1 == T);
    iack_e = (m_owner == 1) && ack;
    dack_e = (m_owner == 2) && ack;
    idat_e = iack_e ? (m_adr[2] ? xdat_i[63:32] : xdat_i[31:0]) : 32'd0;
    chk("rnd_grant", 64'(grant_o), 64'(m_owner));
    chk("rnd_xsiz",  64'(xsiz_o), (m_owner != 0) ? 64'(m_siz) : 64'd0);
    chk("rnd_iack",  64'(iack_o), 64'(iack_e));
    chk("rnd_dack",  64'(dack_o), 64'(dack_e));
    chk("rnd_ierr",  64'(ierr_o), 64'((m_owner == 1) && tmo));
    chk("rnd_derr",  64'(derr_o), 64'((m_owner == 2) && tmo));
    chk("rnd_idat",  64'(idat_o), 64'(idat_e));
    chk("rnd_ddat",  ddat_o, dack_e ? xdat_i : 64'd0);
    if (m_owner != 0) begin
      chk("rnd_xadr", xadr_o, m_adr);
      chk("rnd_xwe",  64'(xwe_o), 64'(m_we));
      chk("rnd_xdat", xdat_o, m_dat);
    end
    // advance one clock
    if (m_owner != 0) begin
      if (ack || tmo) begin
        m_last = m_owner; m_owner = 0; m_waited = 0;
      end else begin
        m_waited++;
      end
    end else begin
      if (isiz_i != 0 && dsiz_i != 0) m_owner = (m_last == 1) ? 2 : 1;
      else if (isiz_i != 0)           m_owner = 1;
      else if (dsiz_i != 0)           m_owner = 2;
      m_waited = 0;
      if (m_owner == 1) begin
        m_adr = iadr_i; m_siz = isiz_i; m_we = 1'b0; m_dat = '0;
      end else if (m_owner == 2) begin
        m_adr = dadr_i; m_siz = dsiz_i; m_we = dwe_i; m_dat = ddat_i;
      end
    end
  endtask

  initial begin
    clear_inputs();

    // -------- table: contention with ack on first bus cycle, then timeouts
    //            isiz  dsiz  xack grant xsiz iack dack derr
    vt.push_back('{2'd2, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd2, 2'd3, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0});
    vt.push_back('{2'd2, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd2, 2'd3, 1'b1, 2'd2, 2'd3, 1'b0, 1'b1, 1'b0});
    vt.push_back('{2'd2, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd2, 2'd3, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1});
    vt.push_back('{2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd1, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd1, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0});
    vt.push_back('{2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});
    vt.push_back('{2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});

    // -------- boot fetch with mid-transfer address change
    reset_assert();
    chk("rst_xsiz",  64'(xsiz_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_xadr",  xadr_o, 64'd0);
    isiz_i = 2'b10; iadr_i = 64'hFFFF_FFFF_FFFF_FF00;
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("boot_idle_grant", 64'(grant_o), 64'd0);
    tick();
    @(negedge clk_i);
    chk("boot_xadr",  xadr_o, 64'hFFFF_FFFF_FFFF_FF00);
    chk("boot_xsiz",  64'(xsiz_o), 64'd2);
    chk("boot_grant", 64'(grant_o), 64'd1);
    chk("boot_xwe",   64'(xwe_o), 64'd0);
    tick();
    iadr_i = 64'h4;
    @(negedge clk_i);
    chk("boot_wait_iack", 64'(iack_o), 64'd0);
    chk("hold_xadr", xadr_o, 64'hFFFF_FFFF_FFFF_FF00);
    tick();
    xack_i = 1'b1; xdat_i = 64'h0000_0013_0000_0000;
    @(negedge clk_i);
    chk("boot_iack", 64'(iack_o), 64'd1);
    chk("boot_idat", 64'(idat_o), 64'd0);
    chk("boot_ierr", 64'(ierr_o), 64'd0);
    chk("boot_dack", 64'(dack_o), 64'd0);
    chk("hold_xadr_ack", xadr_o, 64'hFFFF_FFFF_FFFF_FF00);
    tick();
    isiz_i = 2'b00; xack_i = 1'b0;
    @(negedge clk_i);
    chk("boot_done_xsiz",  64'(xsiz_o), 64'd0);
    chk("boot_done_grant", 64'(grant_o), 64'd0);

    // -------- D write
    dsiz_i = 2'b11; dwe_i = 1'b1; dadr_i = 64'h1000; ddat_i = 64'hDEAD_BEEF_FEED_FACE;
    tick();
    @(negedge clk_i);
    chk("dw_xwe",   64'(xwe_o), 64'd1);
    chk("dw_xdat",  xdat_o, 64'hDEAD_BEEF_FEED_FACE);
    chk("dw_xadr",  xadr_o, 64'h1000);
    chk("dw_xsiz",  64'(xsiz_o), 64'd3);
    chk("dw_grant", 64'(grant_o), 64'd2);
    tick();
    xack_i = 1'b1; xdat_i = 64'h0123_4567_89AB_CDEF;
    @(negedge clk_i);
    chk("dw_dack", 64'(dack_o), 64'd1);
    chk("dw_iack", 64'(iack_o), 64'd0);
    chk("dw_ddat", ddat_o, 64'h0123_4567_89AB_CDEF);
    tick();
    dsiz_i = 2'b00; dwe_i = 1'b0; xack_i = 1'b0;
    @(negedge clk_i);
    chk("dw_done_xsiz", 64'(xsiz_o), 64'd0);

    // -------- reset mid-transfer
    dsiz_i = 2'b01; dadr_i = 64'h3000;
    tick();
    @(negedge clk_i);
    chk("rmt_grant_d", 64'(grant_o), 64'd2);
    tick();
    isiz_i = 2'b10; iadr_i = 64'h40; xack_i = 1'b1;
    reset_i = 1'b0;
    #1;
    chk("rmt_xadr",  xadr_o, 64'd0);
    chk("rmt_xsiz",  64'(xsiz_o), 64'd0);
    chk("rmt_xwe",   64'(xwe_o), 64'd0);
    chk("rmt_xdat",  xdat_o, 64'd0);
    chk("rmt_grant", 64'(grant_o), 64'd0);
    chk("rmt_dack",  64'(dack_o), 64'd0);
    tick();
    chk("rmt_dack_held", 64'(dack_o), 64'd0);
    xack_i = 1'b0;
    reset_i = 1'b1;
    tick();
    @(negedge clk_i);
    chk("rmt_first_i", 64'(grant_o), 64'd1);
    chk("rmt_first_adr", xadr_o, 64'h40);

    // -------- table vectors
    reset_assert();
    iadr_i = 64'h100; dadr_i = 64'h2000; xdat_i = 64'h1122_3344_5566_7788;
    isiz_i = vt[0].isiz; dsiz_i = vt[0].dsiz; xack_i = vt[0].xack;
    reset_i = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      isiz_i = vt[i].isiz; dsiz_i = vt[i].dsiz; xack_i = vt[i].xack;
      @(negedge clk_i);
      chk($sformatf("vec%0d_grant", i), 64'(grant_o), 64'(vt[i].grant));
      chk($sformatf("vec%0d_xsiz", i),  64'(xsiz_o), 64'(vt[i].xsiz));
      chk($sformatf("vec%0d_iack", i),  64'(iack_o), 64'(vt[i].iack));
      chk($sformatf("vec%0d_dack", i),  64'(dack_o), 64'(vt[i].dack));
      chk($sformatf("vec%0d_derr", i),  64'(derr_o), 64'(vt[i].derr));
      chk($sformatf("vec%0d_ierr", i),  64'(ierr_o), 64'd0);
      chk($sformatf("vec%0d_idat", i),  64'(idat_o), vt[i].iack ? 64'h5566_7788 : 64'd0);
      chk($sformatf("vec%0d_ddat", i),  ddat_o, vt[i].dack ? 64'h1122_3344_5566_7788 : 64'd0);
      tick();
    end

    // -------- randomized traffic against the model
    reset_assert();
    model_reset();
    reset_i = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      isiz_i = ($urandom % 2 == 0) ? 2'b10 : 2'b00;
      dsiz_i = 2'($urandom % 4);
      dwe_i  = 1'($urandom % 2);
      iadr_i = {$urandom, $urandom};
      dadr_i = {$urandom, $urandom};
      ddat_i = {$urandom, $urandom};
      xdat_i = {$urandom, $urandom};
      xack_i = ($urandom % 4 == 0);
      @(negedge clk_i);
      model_check_and_step();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
